// File: rtl/postage_maxi_burst_addr.sv
// rtl/postage_maxi_burst_addr.sv - stamp idx*stride to AXI AW burst address over a 4-stage enabled pipe
// Optional burst/stall counters: define POSTAGE_BURST_ADDR_PERF_EN
module postage_maxi_burst_addr #(
  parameter int ADDR_W     = 64,
  parameter int BEAT_SHIFT = 6,
  parameter int ERR_W      = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_idx,
  input  logic [8:0]        s_stride,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [7:0]        aw_len,
  output logic [ERR_W-1:0]  err_cnt
`ifdef POSTAGE_BURST_ADDR_PERF_EN
  ,
  output logic [31:0]       burst_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int OFF_W = 25 + BEAT_SHIFT;

  logic              ce;
  logic              legal;

  logic [15:0]       idx_s1;
  logic [8:0]        stride_s1;
  logic [ADDR_W-1:0] base_s1;
  logic              v_s1;

  logic [24:0]       p_tmp;
  logic [8:0]        stride_s2;
  logic [ADDR_W-1:0] base_s2;
  logic              v_s2;

  logic [24:0]       p_reg;
  logic [8:0]        stride_s3;
  logic [ADDR_W-1:0] base_s3;
  logic              v_s3;

  logic [OFF_W-1:0]  byte_off;

  // A stalled AW beat freezes the whole pipe, so nothing upstream can overrun it.
  assign ce       = !aw_valid || aw_ready;
  assign s_ready  = ce;
  assign legal    = (s_stride != 9'd0) && (s_stride <= 9'd256);
  assign byte_off = {p_reg, {BEAT_SHIFT{1'b0}}};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      idx_s1    <= '0;
      stride_s1 <= '0;
      base_s1   <= '0;
      v_s1      <= 1'b0;
      p_tmp     <= '0;
      stride_s2 <= '0;
      base_s2   <= '0;
      v_s2      <= 1'b0;
      p_reg     <= '0;
      stride_s3 <= '0;
      base_s3   <= '0;
      v_s3      <= 1'b0;
      aw_addr   <= '0;
      aw_len    <= '0;
      aw_valid  <= 1'b0;
    end else if (ce) begin
      idx_s1    <= s_idx;
      stride_s1 <= s_stride;
      base_s1   <= base_addr;
      v_s1      <= s_valid && legal;

      p_tmp     <= 25'(idx_s1) * 25'(stride_s1);
      stride_s2 <= stride_s1;
      base_s2   <= base_s1;
      v_s2      <= v_s1;

      p_reg     <= p_tmp;
      stride_s3 <= stride_s2;
      base_s3   <= base_s2;
      v_s3      <= v_s2;

      // Address sum wraps silently at the top of the address space.
      aw_addr   <= base_s3 + ADDR_W'(byte_off);
      aw_len    <= 8'(stride_s3 - 9'd1);
      aw_valid  <= v_s3;
    end
  end

  // Illegal strides are swallowed at the input; only the counter records them.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_cnt <= '0;
    end else if (ce && s_valid && !legal && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

`ifdef POSTAGE_BURST_ADDR_PERF_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (aw_valid && aw_ready)  burst_cnt <= burst_cnt + 32'd1;
      if (aw_valid && !aw_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
